sao_lcu_ctrl: RTL

- Sequencer for the SAO datapath.
- Accepts one LCU of raster-order pixels on the din/in_en stream and writes them into the local LCU buffer.
- Then scans the buffer pixel by pixel, producing in-LCU coordinates for the offset datapath and absolute 128x128 frame SRAM addresses.
- Owns busy/finish toward the pattern source and sram_we toward the frame SRAM.

---
 rtl/sao_pkg.sv | 52 +++++
 rtl/sao_wr_pipe.sv | 47 ++++
 rtl/sao_lcu_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sao_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sao_pkg
// Purpose  : Shared definitions for the SAO LCU sequencer: frame geometry,
//            LCU size encodings, size lookups and the controller state type.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sao_pkg;

  localparam int IMG_W  = 128;  // square frame, pixels per side
  localparam int ADDR_W = 14;   // log2(IMG_W*IMG_W)
  localparam int BUF_AW = 12;   // LCU buffer index, up to 64x64

  // lcu_size encodings; the reserved code behaves as 64x64
  localparam logic [1:0] LCU_SZ_16  = 2'd0;
  localparam logic [1:0] LCU_SZ_32  = 2'd1;
  localparam logic [1:0] LCU_SZ_64  = 2'd2;
  localparam logic [1:0] LCU_SZ_RSV = 2'd3;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    PROC  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // min(lcu_size, 2): log2(S/16)
  function automatic logic [1:0] size_code(input logic [1:0] lcu_size);
    size_code = (lcu_size == LCU_SZ_RSV) ? LCU_SZ_64 : lcu_size;
  endfunction

  // LCU side S in pixels
  function automatic logic [6:0] size_of(input logic [1:0] lcu_size);
    case (size_code(lcu_size))
      LCU_SZ_16: size_of = 7'd16;
      LCU_SZ_32: size_of = 7'd32;
      default:   size_of = 7'd64;
    endcase
  endfunction

  // pixels per LCU, N = S*S
  function automatic logic [12:0] npix_of(input logic [1:0] lcu_size);
    case (size_code(lcu_size))
      LCU_SZ_16: npix_of = 13'd256;
      LCU_SZ_32: npix_of = 13'd1024;
      default:   npix_of = 13'd4096;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sao_wr_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sao_wr_pipe
// Purpose  : DEPTH-stage delay line carrying the frame SRAM write strobe and
//            address, so the write lines up with the datapath result.
// Ports    : clk, reset (async, active-low)
//            in_valid/in_addr   - strobe and address at buffer-read issue
//            out_valid/out_addr - same, DEPTH cycles later
// Revision : 1.0 - initial release
// ============================================================================
module sao_wr_pipe #(
  parameter int DEPTH = 2,              // must be >= 1
  parameter int W     = sao_pkg::ADDR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_addr,
  output logic         out_valid,
  output logic [W-1:0] out_addr
);

  logic [DEPTH-1:0] r_vld;
  logic [W-1:0]     r_addr [DEPTH];

  // Reset clears the valid bits, so an aborted LCU leaves no stale writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
      end
    end else begin
      r_vld[0]  <= in_valid;
      r_addr[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_addr[i] <= r_addr[i-1];
      end
    end
  end

  assign out_valid = r_vld[DEPTH-1];
  assign out_addr  = r_addr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sao_lcu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sao_lcu_ctrl
// Purpose  : SAO sequencer. Loads one LCU of raster pixels into the local
//            buffer, then scans it pixel by pixel, emitting in-LCU
//            coordinates and delayed absolute frame SRAM writes.
// Ports    : clk, reset (async, active-low)
//            in_en                  - pixel valid, taken only while busy=0
//            lcu_x/lcu_y/lcu_size   - LCU position/size, sampled on pixel 0
//            buf_we/buf_waddr       - LCU buffer write port
//            buf_raddr/pix_x/pix_y  - buffer read index and coordinates
//            sram_we/sram_addr      - frame SRAM write, PIPE_LAT after read
//            busy/finish            - flow control / end-of-frame pulse
// Revision : 1.0 - initial release
// ============================================================================
module sao_lcu_ctrl #(
  parameter int IMG_W    = sao_pkg::IMG_W,
  parameter int ADDR_W   = sao_pkg::ADDR_W,
  parameter int BUF_AW   = sao_pkg::BUF_AW,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en,
  input  logic [2:0]        lcu_x,
  input  logic [2:0]        lcu_y,
  input  logic [1:0]        lcu_size,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_waddr,
  output logic [BUF_AW-1:0] buf_raddr,
  output logic [5:0]        pix_x,
  output logic [5:0]        pix_y,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              busy,
  output logic              finish
);

  import sao_pkg::*;

  localparam int AW1    = ADDR_W + 1;
  localparam int DCNT_W = $clog2(PIPE_LAT + 2);

  state_t            r_state, w_state_nxt;
  logic [BUF_AW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]        r_lx, r_ly, w_lx_nxt, w_ly_nxt;
  logic [1:0]        r_ls, w_ls_nxt;
  logic [5:0]        r_px, r_py, w_px_nxt, w_py_nxt;
  logic [DCNT_W-1:0] r_dcnt, w_dcnt_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_finish, w_finish_nxt;

  logic [1:0]        w_ls_load;
  logic [12:0]       w_n_load;
  logic              w_accept;
  logic              w_last_pix;
  logic [6:0]        w_s;
  logic [5:0]        w_pmax;
  logic [7:0]        w_last_lcu;
  logic              w_at_end;
  logic              w_issue;
  logic [AW1-1:0]    w_row;
  logic [ADDR_W-1:0] w_issue_addr;

  // On pixel 0 the size register is not yet loaded, so the size being
  // sampled decides N; afterwards only the latched size counts, which keeps
  // mid-LCU changes of lcu_size from shortening or stretching the LCU.
  assign w_ls_load  = (r_cnt == '0) ? lcu_size : r_ls;
  assign w_n_load   = npix_of(w_ls_load);
  assign w_accept   = in_en & ~r_busy & (r_state == LOAD);
  assign w_last_pix = (13'(r_cnt) == (w_n_load - 13'd1));

  assign w_s        = size_of(r_ls);
  assign w_pmax     = 6'(w_s - 7'd1);
  assign w_last_lcu = 8'((IMG_W / 16) >> size_code(r_ls)) - 8'd1;
  assign w_at_end   = ({5'd0, r_lx} == w_last_lcu) && ({5'd0, r_ly} == w_last_lcu);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= LOAD;
      r_cnt    <= '0;
      r_lx     <= '0;
      r_ly     <= '0;
      r_ls     <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_dcnt   <= '0;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_lx     <= w_lx_nxt;
      r_ly     <= w_ly_nxt;
      r_ls     <= w_ls_nxt;
      r_px     <= w_px_nxt;
      r_py     <= w_py_nxt;
      r_dcnt   <= w_dcnt_nxt;
      r_busy   <= w_busy_nxt;
      r_finish <= w_finish_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_lx_nxt     = r_lx;
    w_ly_nxt     = r_ly;
    w_ls_nxt     = r_ls;
    w_px_nxt     = r_px;
    w_py_nxt     = r_py;
    w_dcnt_nxt   = r_dcnt;
    w_busy_nxt   = r_busy;
    w_finish_nxt = 1'b0;

    case (r_state)
      LOAD: begin
        if (w_accept) begin
          if (r_cnt == '0) begin
            w_lx_nxt = lcu_x;
            w_ly_nxt = lcu_y;
            w_ls_nxt = lcu_size;
          end
          if (w_last_pix) begin
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b1;
            w_state_nxt = PROC;
          end else begin
            w_cnt_nxt = r_cnt + BUF_AW'(1);
          end
        end
      end

      PROC: begin
        if (r_px == w_pmax) begin
          w_px_nxt = '0;
          if (r_py == w_pmax) begin
            w_py_nxt    = '0;
            w_dcnt_nxt  = '0;
            w_state_nxt = DRAIN;
          end else begin
            w_py_nxt = r_py + 6'd1;
          end
        end else begin
          w_px_nxt = r_px + 6'd1;
        end
      end

      // PIPE_LAT cycles flush the write pipe; the extra compare cycle makes
      // busy fall N + PIPE_LAT + 1 cycles after the last accepted pixel.
      DRAIN: begin
        if (r_dcnt == DCNT_W'(PIPE_LAT)) begin
          if (w_at_end) begin
            w_state_nxt  = DONE;
            w_finish_nxt = 1'b1;
          end else begin
            w_state_nxt = LOAD;
            w_busy_nxt  = 1'b0;
          end
        end else begin
          w_dcnt_nxt = r_dcnt + DCNT_W'(1);
        end
      end

      DONE: begin
        // terminal until reset; busy stays high
      end

      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  // Read side: px/py are zero outside PROC, so buf_raddr rests at 0.
  assign w_issue   = (r_state == PROC);
  assign buf_raddr = BUF_AW'(13'(r_py) * 13'(w_s) + 13'(r_px));
  assign pix_x     = r_px;
  assign pix_y     = r_py;

  // Absolute frame address at issue, one bit wider then truncated.
  assign w_row        = AW1'(r_ly) * AW1'(w_s) + AW1'(r_py);
  assign w_issue_addr = ADDR_W'(w_row * AW1'(IMG_W) + AW1'(r_lx) * AW1'(w_s) + AW1'(r_px));

  sao_wr_pipe #(
    .DEPTH (PIPE_LAT),
    .W     (ADDR_W)
  ) u_wr_pipe (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (w_issue),
    .in_addr   (w_issue_addr),
    .out_valid (sram_we),
    .out_addr  (sram_addr)
  );

  assign buf_we    = w_accept;
  assign buf_waddr = r_cnt;
  assign busy      = r_busy;
  assign finish    = r_finish;

endmodule
`default_nettype wire
